// File: rtl/vga_cmd_timing.sv
// rtl/vga_cmd_timing.sv - VGA sync/pixel generator that drains colour/mode commands from a byte FIFO
module vga_cmd_timing #(
    parameter int CLK_DIV   = 4,
    parameter int H_VISIBLE = 800,
    parameter int H_FP      = 40,
    parameter int H_SYNC    = 128,
    parameter int H_BP      = 88,
    parameter int V_VISIBLE = 600,
    parameter int V_FP      = 1,
    parameter int V_SYNC    = 4,
    parameter int V_BP      = 23,
    parameter bit HSYNC_POL = 1'b1,
    parameter bit VSYNC_POL = 1'b1,
    parameter int RD_LATCH  = 6,
    parameter int RD_END    = 8
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [7:0] cmd_data,
    input  logic       cmd_nef,
    output logic       cmd_nrd,
    output logic       hsync,
    output logic       vsync,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       frame_start
);
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int RT_W    = $clog2(RD_END + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [12:0] HS_START = 13'(H_VISIBLE + H_FP);
    localparam logic [12:0] HS_END   = 13'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [12:0] VS_START = 13'(V_VISIBLE + V_FP);
    localparam logic [12:0] VS_END   = 13'(V_VISIBLE + V_FP + V_SYNC);

    typedef enum logic [1:0] {RD_IDLE, RD_STROBE, RD_RECOVER} rd_state_t;

    logic [DIV_W-1:0] div_cnt;
    logic [11:0]      hcount;
    logic [11:0]      vcount;
    logic             tick;
    logic             h_last;
    logic             v_last;
    logic             frame_wrap;
    logic             h_act;
    logic             v_act;
    logic             pix_on;

    rd_state_t        rd_state;
    logic [RT_W-1:0]  rtick;
    logic [RT_W-1:0]  rtick_next;
    logic             idle_hold;
    logic             nef_meta;
    logic             nef_s;
    logic [7:0]       cmd_byte;
    logic             byte_valid;

    logic [3:0] pend_red, pend_green, pend_blue;
    logic       pend_mode, pend_blank;
    logic [3:0] act_red, act_green, act_blue;
    logic       act_mode, act_blank;

    assign tick       = (div_cnt == '0);
    assign h_last     = (hcount == H_LAST);
    assign v_last     = (vcount == V_LAST);
    assign frame_wrap = tick && h_last && v_last;
    assign h_act      = ({1'b0, hcount} >= HS_START) && ({1'b0, hcount} < HS_END);
    assign v_act      = ({1'b0, vcount} >= VS_START) && ({1'b0, vcount} < VS_END);
    assign pix_on     = (hcount < 12'(H_VISIBLE)) && (vcount < 12'(V_VISIBLE)) && !act_blank;
    assign rtick_next = rtick + 1'b1;

    function automatic logic [3:0] shade(input logic [3:0] c, input logic on,
                                         input logic ramp_mode, input logic [3:0] ramp);
        if (!on)
            return 4'd0;
        if (ramp_mode)
            return (c != 4'd0) ? ramp : 4'd0;
        return c;
    endfunction

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            div_cnt <= '0;
            hcount  <= '0;
            vcount  <= '0;
        end else begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
            if (tick) begin
                hcount <= h_last ? 12'd0 : hcount + 12'd1;
                if (h_last)
                    vcount <= v_last ? 12'd0 : vcount + 12'd1;
            end
        end
    end

    // Outputs describe the pixel whose counter value was current at the tick.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            hsync       <= !HSYNC_POL;
            vsync       <= !VSYNC_POL;
            red         <= 4'd0;
            green       <= 4'd0;
            blue        <= 4'd0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame_wrap;
            if (tick) begin
                hsync <= h_act ? HSYNC_POL : !HSYNC_POL;
                vsync <= v_act ? VSYNC_POL : !VSYNC_POL;
                red   <= shade(act_red,   pix_on, act_mode, hcount[8:5]);
                green <= shade(act_green, pix_on, act_mode, hcount[8:5]);
                blue  <= shade(act_blue,  pix_on, act_mode, hcount[8:5]);
            end
        end
    end

    // IDLE dwells one extra cycle after a strobe so a stale synchronised
    // not-empty flag cannot launch a read of an already drained FIFO.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            nef_meta   <= 1'b0;
            nef_s      <= 1'b0;
            rd_state   <= RD_IDLE;
            cmd_nrd    <= 1'b1;
            rtick      <= '0;
            idle_hold  <= 1'b0;
            cmd_byte   <= 8'd0;
            byte_valid <= 1'b0;
            pend_red   <= 4'd0;
            pend_green <= 4'd0;
            pend_blue  <= 4'd0;
            pend_mode  <= 1'b0;
            pend_blank <= 1'b0;
        end else begin
            nef_meta <= cmd_nef;
            nef_s    <= nef_meta;
            if (byte_valid) begin
                byte_valid <= 1'b0;
                casez (cmd_byte)
                    8'b00??????: pend_red   <= cmd_byte[3:0];
                    8'b01??????: pend_green <= cmd_byte[3:0];
                    8'b10??????: pend_blue  <= cmd_byte[3:0];
                    default: begin
                        pend_mode  <= cmd_byte[0];
                        pend_blank <= cmd_byte[1];
                    end
                endcase
            end
            case (rd_state)
                RD_IDLE: begin
                    if (idle_hold) begin
                        idle_hold <= 1'b0;
                    end else if (nef_s && !byte_valid) begin
                        rd_state <= RD_STROBE;
                        cmd_nrd  <= 1'b0;
                        rtick    <= '0;
                    end
                end
                RD_STROBE: begin
                    rtick <= rtick_next;
                    if (rtick_next == RT_W'(RD_LATCH)) begin
                        cmd_byte   <= cmd_data;
                        byte_valid <= 1'b1;
                    end
                    if (rtick_next == RT_W'(RD_END)) begin
                        cmd_nrd  <= 1'b1;
                        rd_state <= RD_RECOVER;
                    end
                end
                RD_RECOVER: begin
                    rd_state  <= RD_IDLE;
                    idle_hold <= 1'b1;
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

    // Active registers sample pending before any same-cycle decode lands.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            act_red   <= 4'd0;
            act_green <= 4'd0;
            act_blue  <= 4'd0;
            act_mode  <= 1'b0;
            act_blank <= 1'b0;
        end else if (frame_wrap) begin
            act_red   <= pend_red;
            act_green <= pend_green;
            act_blue  <= pend_blue;
            act_mode  <= pend_mode;
            act_blank <= pend_blank;
        end
    end
endmodule

// File: tb/tb_vga_cmd_timing.sv
// tb/tb_vga_cmd_timing.sv - scoreboard bench for vga_cmd_timing with a small video mode
module tb_vga_cmd_timing;
    localparam int D    = 2;
    localparam int HV   = 520;
    localparam int HFP  = 8;
    localparam int HS   = 16;
    localparam int HBP  = 8;
    localparam int VV   = 3;
    localparam int VFP  = 1;
    localparam int VS   = 1;
    localparam int VBP  = 1;
    localparam bit HPOL = 1'b0;
    localparam bit VPOL = 1'b1;
    localparam int RD_LATCH = 6;
    localparam int RD_END   = 8;
    localparam int HT = HV + HFP + HS + HBP;
    localparam int VT = VV + VFP + VS + VBP;
    localparam int FT = HT * VT;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic [7:0] cmd_data = 8'd0;
    logic       cmd_nef = 1'b0;
    logic       cmd_nrd;
    logic       hsync, vsync;
    logic [3:0] red, green, blue;
    logic       frame_start;

    vga_cmd_timing #(
        .CLK_DIV(D), .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .HSYNC_POL(HPOL), .VSYNC_POL(VPOL), .RD_LATCH(RD_LATCH), .RD_END(RD_END)
    ) dut (
        .clk(clk), .nrst(nrst), .cmd_data(cmd_data), .cmd_nef(cmd_nef), .cmd_nrd(cmd_nrd),
        .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        logic       fs;
    } out_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        logic       mode;
        logic       blank;
    } regs_t;

    typedef struct {
        int         dec_edge;
        logic [7:0] data;
    } cmd_t;

    int         checks = 0;
    int         errors = 0;
    int         edge_n = 0;
    int         reads = 0;
    int         last_fall = 0;
    int         last_dec_edge = 0;
    logic       nrd_prev = 1'b1;
    bit         burst_cont = 1'b0;
    logic       hs_prev = !HPOL;
    logic       vs_prev = !VPOL;
    int         hs_rise = 0;
    int         vs_rise = 0;
    logic [7:0] fifo_q[$];
    cmd_t       decodes[$];
    out_t       exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    function automatic int wrap_edge(input int f);
        return (f * FT - 1) * D + 1;
    endfunction

    // Register contents in force after every command decoded before edge w.
    function automatic regs_t regs_at(input int w);
        regs_t r = '0;
        foreach (decodes[i]) begin
            if (decodes[i].dec_edge < w) begin
                case (decodes[i].data[7:6])
                    2'b00: r.r = decodes[i].data[3:0];
                    2'b01: r.g = decodes[i].data[3:0];
                    2'b10: r.b = decodes[i].data[3:0];
                    default: begin
                        r.mode  = decodes[i].data[0];
                        r.blank = decodes[i].data[1];
                    end
                endcase
            end
        end
        return r;
    endfunction

    function automatic logic [3:0] model_colour(input logic [3:0] c, input regs_t a,
                                                input bit vis, input int h);
        if (!vis || a.blank)
            return 4'd0;
        if (!a.mode)
            return c;
        return (c != 4'd0) ? 4'((h / 32) % 16) : 4'd0;
    endfunction

    function automatic out_t expect_at(input int e);
        int    p, h, v, f;
        bit    vis;
        regs_t a;
        out_t  o;
        p = (e - 1) / D;
        h = p % HT;
        v = (p / HT) % VT;
        f = p / FT;
        a = (f == 0) ? regs_t'(0) : regs_at(wrap_edge(f));
        vis  = (h < HV) && (v < VV);
        o.hs = (h >= HV + HFP && h < HV + HFP + HS) ? HPOL : !HPOL;
        o.vs = (v >= VV + VFP && v < VV + VFP + VS) ? VPOL : !VPOL;
        o.r  = model_colour(a.r, a, vis, h);
        o.g  = model_colour(a.g, a, vis, h);
        o.b  = model_colour(a.b, a, vis, h);
        o.fs = ((e - 1) % D == 0) && (p % FT == FT - 1);
        return o;
    endfunction

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            edge_n = 0;
            exp_q.delete();
        end else begin
            edge_n++;
            exp_q.push_back(expect_at(edge_n));
        end
    end

    always @(negedge clk) begin
        out_t e;
        out_t a;
        if (!nrst) begin
            hs_prev = !HPOL;
            vs_prev = !VPOL;
            hs_rise = 0;
            vs_rise = 0;
        end else begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {hsync, vsync, red, green, blue, frame_start};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL pixel_out at edge %0d: got %h, required %h (hs,vs,r,g,b,fs)",
                             edge_n, a, e);
                end
            end
            if (hsync == HPOL && hs_prev != HPOL) begin
                if (hs_rise > 0) chk("hsync_period", edge_n - hs_rise, HT * D);
                hs_rise = edge_n;
            end
            if (hsync != HPOL && hs_prev == HPOL && hs_rise > 0)
                chk("hsync_width", edge_n - hs_rise, HS * D);
            if (vsync == VPOL && vs_prev != VPOL) begin
                if (vs_rise > 0) chk("vsync_period", edge_n - vs_rise, VT * HT * D);
                vs_rise = edge_n;
            end
            if (vsync != VPOL && vs_prev == VPOL && vs_rise > 0)
                chk("vsync_width", edge_n - vs_rise, VS * HT * D);
            hs_prev = hsync;
            vs_prev = vsync;
        end
    end

    // FIFO model: data is valid only across the edge on which it must be sampled.
    always @(negedge clk) begin
        if (!nrst) begin
            fifo_q.delete();
            decodes.delete();
            nrd_prev   = 1'b1;
            burst_cont = 1'b0;
            cmd_nef    = 1'b0;
        end else begin
            if (nrd_prev && !cmd_nrd) begin
                reads++;
                if (burst_cont) chk("rd_spacing", edge_n - last_fall, RD_END + 3);
                last_fall     = edge_n;
                last_dec_edge = edge_n + RD_LATCH + 1;
                if (fifo_q.size() > 0) begin
                    decodes.push_back('{dec_edge: last_dec_edge, data: fifo_q[0]});
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL rd_while_empty: read started at edge %0d, required none", edge_n);
                end
            end
            if (!nrd_prev && cmd_nrd) begin
                chk("rd_width", edge_n - last_fall, RD_END);
                if (fifo_q.size() > 0) fifo_q.delete(0);
                burst_cont = (fifo_q.size() > 0);
            end
            nrd_prev = cmd_nrd;
            cmd_nef  = (fifo_q.size() > 0);
            if (!cmd_nrd && fifo_q.size() > 0 && edge_n == last_fall + RD_LATCH - 1)
                cmd_data = fifo_q[0];
            else
                cmd_data = 8'($urandom);
        end
    end

    task automatic push_byte(input logic [7:0] b);
        fifo_q.push_back(b);
        cmd_nef = 1'b1;
    endtask

    task automatic wait_edge(input int target);
        int guard = 0;
        while (edge_n < target && guard < 100000) begin
            @(negedge clk);
            guard++;
        end
        if (edge_n < target) begin
            checks++;
            errors++;
            $display("FAIL wait_edge: reached %0d, required %0d", edge_n, target);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_nrd"}, cmd_nrd, 1);
        chk({tag, "_hsync"}, hsync, !HPOL);
        chk({tag, "_vsync"}, vsync, !VPOL);
        chk({tag, "_rgb"}, {red, green, blue}, 0);
        chk({tag, "_fs"}, frame_start, 0);
    endtask

    initial begin
        int r0;
        int a;
        int guard;
        repeat (4) @(negedge clk);
        check_idle_outputs("reset");
        @(negedge clk);
        nrst = 1'b1;

        // Abort a read three cycles into the strobe; the byte must vanish.
        @(negedge clk);
        push_byte(8'hC2);
        guard = 0;
        while (cmd_nrd && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("mid_read_fall", cmd_nrd, 0);
        repeat (3) @(posedge clk);
        #2 nrst = 1'b0;
        #1 check_idle_outputs("mid_read_reset");
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;

        // Colour burst in the middle of frame 0.
        wait_edge($urandom_range(200, 3000));
        r0 = reads;
        push_byte(8'h0F);
        push_byte(8'h4A);
        push_byte(8'h83);
        wait_edge(edge_n + 80);
        chk("burst_reads", reads - r0, 3);

        // Ramp mode with red=F, green=blue=0 from frame 2.
        wait_edge(wrap_edge(1) + $urandom_range(500, 3000));
        push_byte(8'h40);
        push_byte(8'h80);
        push_byte(8'hC1);

        // Blank command decoded exactly on the frame-3 commit edge.
        a = wrap_edge(3) - RD_LATCH - 3;
        wait_edge(a - 1);
        r0 = reads;
        push_byte(8'hC2);
        wait_edge(edge_n + 20);
        chk("collision_reads", reads - r0, 1);
        chk("collision_decode_edge", last_dec_edge, wrap_edge(3));

        // Random commands in frame 4, visible from frame 5.
        wait_edge(wrap_edge(4) + $urandom_range(300, 4000));
        for (int i = 0; i < 4; i++)
            push_byte(8'($urandom));

        wait_edge(wrap_edge(6) + 100);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
